// File: rtl/pong_pkg.sv
// pong_pkg: constants and helpers shared by the Pong VGA renderer.
//   - Default 640x480@60Hz timing (pixels / lines) and 25 MHz pixel divider
//   - Default object sizes (paddle, ball)
//   - 12-bit {R,G,B} colour constants
//   - pos_t plus POS_X/POS_Y slice helpers for the 24-bit {x,y} position words
//   - obj_hit: 13-bit rectangle hit test, so x+W never wraps back on screen
package pong_pkg;

  localparam int VGA_CLK_DIV  = 4;
  localparam int VGA_H_VIS    = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_VIS    = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  localparam int VGA_PADDLE_W = 8;
  localparam int VGA_PADDLE_H = 64;
  localparam int VGA_BALL_SZ  = 8;

  localparam logic [11:0] COL_BALL   = 12'hFFF;
  localparam logic [11:0] COL_PLAYER = 12'h0F0;
  localparam logic [11:0] COL_COMP   = 12'hF00;
  localparam logic [11:0] COL_LINE   = 12'h888;
  localparam logic [11:0] COL_FLASH  = 12'h300;
  localparam logic [11:0] COL_BG     = 12'h000;

  typedef struct packed {
    logic [11:0] x;
    logic [11:0] y;
  } pos_t;

  function automatic logic [11:0] pos_x(input logic [23:0] p);
    return p[23:12];
  endfunction

  function automatic logic [11:0] pos_y(input logic [23:0] p);
    return p[11:0];
  endfunction

  // Widened to 13 bits so an object near x=4095 stays off screen instead of
  // wrapping its right edge around to column 0.
  function automatic logic obj_hit(input logic [11:0] ox, input logic [11:0] oy,
                                   input logic [9:0] h, input logic [9:0] v,
                                   input logic [12:0] w, input logic [12:0] ht);
    logic [12:0] x0, y0, hx, vy;
    x0 = {1'b0, ox};
    y0 = {1'b0, oy};
    hx = {3'b000, h};
    vy = {3'b000, v};
    return (hx >= x0) && (hx < x0 + w) && (vy >= y0) && (vy < y0 + ht);
  endfunction

endpackage

// File: rtl/vga_timing.sv
// vga_timing: pixel-clock divider and VGA raster counters.
//   clk        in   system clock
//   reset      in   synchronous, active-high
//   pix_en     out  one-cycle strobe every CLK_DIV clocks; all raster state steps on it
//   hcnt/vcnt  out  current column / line (0..H_TOT-1, 0..V_TOT-1)
//   hsync_raw  out  combinational active-low hsync for the current column
//   vsync_raw  out  combinational active-low vsync for the current line
//   visible    out  current (hcnt,vcnt) lies inside the active picture
module vga_timing
  import pong_pkg::*;
#(
  parameter int CLK_DIV = VGA_CLK_DIV,
  parameter int H_VIS   = VGA_H_VIS,
  parameter int H_FP    = VGA_H_FP,
  parameter int H_SYNC  = VGA_H_SYNC,
  parameter int H_BP    = VGA_H_BP,
  parameter int V_VIS   = VGA_V_VIS,
  parameter int V_FP    = VGA_V_FP,
  parameter int V_SYNC  = VGA_V_SYNC,
  parameter int V_BP    = VGA_V_BP
) (
  input  logic       clk,
  input  logic       reset,
  output logic       pix_en,
  output logic [9:0] hcnt,
  output logic [9:0] vcnt,
  output logic       hsync_raw,
  output logic       vsync_raw,
  output logic       visible
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0] div_cnt;

  assign pix_en = (div_cnt == DW'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
      hcnt    <= '0;
      vcnt    <= '0;
    end else begin
      div_cnt <= pix_en ? '0 : div_cnt + 1'b1;
      if (pix_en) begin
        if (hcnt == 10'(H_TOT - 1)) begin
          hcnt <= '0;
          vcnt <= (vcnt == 10'(V_TOT - 1)) ? '0 : vcnt + 1'b1;
        end else begin
          hcnt <= hcnt + 1'b1;
        end
      end
    end
  end

  assign hsync_raw = !((hcnt >= 10'(H_VIS + H_FP)) && (hcnt <= 10'(H_VIS + H_FP + H_SYNC - 1)));
  assign vsync_raw = !((vcnt >= 10'(V_VIS + V_FP)) && (vcnt <= 10'(V_VIS + V_FP + V_SYNC - 1)));
  assign visible   = (hcnt < 10'(H_VIS)) && (vcnt < 10'(V_VIS));

endmodule

// File: rtl/pong_vga_render.sv
// pong_vga_render: draws the Pong playfield onto a VGA raster.
//   CLK_100MHz        in   system clock
//   Reset             in   synchronous, active-high
//   PPosition         in   player paddle top-left {x[23:12], y[11:0]}
//   CPosition         in   computer paddle top-left
//   BPosition         in   ball top-left
//   PScore/CScore     in   scored flags, OR-ed into a background flash
//   hsync/vsync       out  active-low syncs, registered with the colour
//   red/green/blue    out  4-bit colour channels
//   frame_start       out  one-clock pulse on the cycle the positions are snapshotted
// Positions are only sampled at the first pixel of vertical blank, so a frame
// is always drawn from one consistent set of coordinates.
module pong_vga_render
  import pong_pkg::*;
#(
  parameter int CLK_DIV  = VGA_CLK_DIV,
  parameter int H_VIS    = VGA_H_VIS,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_VIS    = VGA_V_VIS,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter int PADDLE_W = VGA_PADDLE_W,
  parameter int PADDLE_H = VGA_PADDLE_H,
  parameter int BALL_SZ  = VGA_BALL_SZ
) (
  input  logic        CLK_100MHz,
  input  logic        Reset,
  input  logic [23:0] PPosition,
  input  logic [23:0] CPosition,
  input  logic [23:0] BPosition,
  input  logic        PScore,
  input  logic        CScore,
  output logic        hsync,
  output logic        vsync,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue,
  output logic        frame_start
);

  // Centre line is four columns wide, straddling the screen midpoint.
  localparam logic [9:0] CL_LO = 10'(H_VIS / 2 - 2);
  localparam logic [9:0] CL_HI = 10'(H_VIS / 2 + 1);

  logic       pix_en, hs_raw, vs_raw, visible;
  logic [9:0] hcnt, vcnt;

  vga_timing #(
    .CLK_DIV(CLK_DIV), .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk       (CLK_100MHz),
    .reset     (Reset),
    .pix_en    (pix_en),
    .hcnt      (hcnt),
    .vcnt      (vcnt),
    .hsync_raw (hs_raw),
    .vsync_raw (vs_raw),
    .visible   (visible)
  );

  pos_t       p_snap, c_snap, b_snap;
  logic       score_flash;
  logic       snap_now;
  logic [11:0] pix_rgb, rgb_q;

  assign snap_now = pix_en && (hcnt == '0) && (vcnt == 10'(V_VIS));

  always_comb begin
    pix_rgb = score_flash ? COL_FLASH : COL_BG;
    if (obj_hit(b_snap.x, b_snap.y, hcnt, vcnt, 13'(BALL_SZ), 13'(BALL_SZ)))
      pix_rgb = COL_BALL;
    else if (obj_hit(p_snap.x, p_snap.y, hcnt, vcnt, 13'(PADDLE_W), 13'(PADDLE_H)))
      pix_rgb = COL_PLAYER;
    else if (obj_hit(c_snap.x, c_snap.y, hcnt, vcnt, 13'(PADDLE_W), 13'(PADDLE_H)))
      pix_rgb = COL_COMP;
    else if ((hcnt >= CL_LO) && (hcnt <= CL_HI) && !vcnt[4])
      pix_rgb = COL_LINE;
    if (!visible)
      pix_rgb = COL_BG;
  end

  always_ff @(posedge CLK_100MHz) begin
    if (Reset) begin
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      rgb_q       <= '0;
      frame_start <= 1'b0;
      p_snap      <= '0;
      c_snap      <= '0;
      b_snap      <= '0;
      score_flash <= 1'b0;
    end else begin
      frame_start <= snap_now;
      if (pix_en) begin
        hsync <= hs_raw;
        vsync <= vs_raw;
        rgb_q <= pix_rgb;
      end
      if (snap_now) begin
        p_snap      <= '{x: pos_x(PPosition), y: pos_y(PPosition)};
        c_snap      <= '{x: pos_x(CPosition), y: pos_y(CPosition)};
        b_snap      <= '{x: pos_x(BPosition), y: pos_y(BPosition)};
        score_flash <= PScore | CScore;
      end
    end
  end

  assign red   = rgb_q[11:8];
  assign green = rgb_q[7:4];
  assign blue  = rgb_q[3:0];

endmodule

// File: tb/tb_pong_vga_render.sv
// Bench for pong_vga_render on a shrunken raster (64x40 total, 48x32 visible)
// so several whole frames fit in a short run. Expected outputs come from the
// clock count since reset: pixel n is registered on clock 4*(n+1).
module tb_pong_vga_render;

  localparam int CLK_DIV = 4;
  localparam int H_VIS = 48, H_FP = 4, H_SYNC = 8, H_BP = 4;
  localparam int V_VIS = 32, V_FP = 2, V_SYNC = 2, V_BP = 4;
  localparam int PW = 8, PH = 16, BS = 8;
  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int FRAME = H_TOT * V_TOT;
  localparam int SNAP  = V_VIS * H_TOT;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [23:0] ppos, cpos, bpos;
  logic        psc, csc;
  logic        hsync, vsync, frame_start;
  logic [3:0]  red, green, blue;

  pong_vga_render #(
    .CLK_DIV(CLK_DIV), .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .PADDLE_W(PW), .PADDLE_H(PH), .BALL_SZ(BS)
  ) dut (
    .CLK_100MHz(clk), .Reset(rst),
    .PPosition(ppos), .CPosition(cpos), .BPosition(bpos),
    .PScore(psc), .CScore(csc),
    .hsync(hsync), .vsync(vsync),
    .red(red), .green(green), .blue(blue),
    .frame_start(frame_start)
  );

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, pc = 0;

  // reference state: snapshot in effect and expected outputs
  int s_bx, s_by, s_px, s_py, s_cx, s_cy;
  bit s_fl;
  bit e_hs, e_vs, e_fs;
  logic [11:0] e_rgb;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit inbox(int h, int v, int x, int y, int w, int ht);
    return h >= x && h < x + w && v >= y && v < y + ht;
  endfunction

  function automatic logic [11:0] ref_rgb(int h, int v);
    if (h >= H_VIS || v >= V_VIS) return 12'h000;
    if (inbox(h, v, s_bx, s_by, BS, BS)) return 12'hFFF;
    if (inbox(h, v, s_px, s_py, PW, PH)) return 12'h0F0;
    if (inbox(h, v, s_cx, s_cy, PW, PH)) return 12'hF00;
    if (h >= H_VIS/2 - 2 && h <= H_VIS/2 + 1 && ((v / 16) % 2) == 0) return 12'h888;
    return s_fl ? 12'h300 : 12'h000;
  endfunction

  function automatic logic [23:0] rand_pos();
    logic [11:0] x, y;
    x = ($urandom_range(0, 7) == 0) ? 12'($urandom_range(4088, 4095)) : 12'($urandom_range(0, H_VIS + 4));
    y = ($urandom_range(0, 7) == 0) ? 12'($urandom_range(4088, 4095)) : 12'($urandom_range(0, V_VIS + 4));
    return {x, y};
  endfunction

  task automatic load_plan();
    case (pc)
      0: begin  // ball over player paddle, computer paddle visible
        bpos = {12'd20, 12'd20}; ppos = {12'd20, 12'd20}; cpos = {12'd30, 12'd2};
        psc = 1'b0; csc = 1'b0;
      end
      1: begin  // paddle clipped at right/bottom, far-off computer paddle, flash
        bpos = {12'd10, 12'd5}; ppos = {12'(H_VIS - 4), 12'(V_VIS - 10)};
        cpos = {12'd4090, 12'd3}; psc = 1'b1; csc = 1'b0;
      end
      2: begin  // flash must clear again
        bpos = rand_pos(); ppos = rand_pos(); cpos = rand_pos(); psc = 1'b0; csc = 1'b0;
      end
      default: begin
        bpos = rand_pos(); ppos = rand_pos(); cpos = rand_pos();
        psc = 1'($urandom_range(0, 1)); csc = 1'($urandom_range(0, 1));
      end
    endcase
    pc++;
  endtask

  // Hold the planned positions across the snapshot edge; scribble elsewhere.
  task automatic drive();
    int d;
    if (rst) return;
    d = (cyc / CLK_DIV) % FRAME;
    if (d == SNAP - 2 && cyc % CLK_DIV == 0) load_plan();
    else if (!(d >= SNAP - 2 && d <= SNAP + 1) && $urandom_range(0, 31) == 0) begin
      bpos = $urandom; ppos = $urandom; cpos = $urandom;
      psc = 1'($urandom_range(0, 1)); csc = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic step();
    int n, h, v;
    @(negedge clk);
    if (rst) begin
      cyc = 0;
      e_hs = 1'b1; e_vs = 1'b1; e_rgb = 12'h000; e_fs = 1'b0;
      s_bx = 0; s_by = 0; s_px = 0; s_py = 0; s_cx = 0; s_cy = 0; s_fl = 1'b0;
    end else begin
      cyc++;
      e_fs = 1'b0;
      if (cyc % CLK_DIV == 0) begin
        n = cyc / CLK_DIV - 1;
        h = n % H_TOT;
        v = (n / H_TOT) % V_TOT;
        e_hs  = !(h >= H_VIS + H_FP && h < H_VIS + H_FP + H_SYNC);
        e_vs  = !(v >= V_VIS + V_FP && v < V_VIS + V_FP + V_SYNC);
        e_rgb = ref_rgb(h, v);
        if (n % FRAME == SNAP) begin
          e_fs = 1'b1;
          s_bx = int'(bpos[23:12]); s_by = int'(bpos[11:0]);
          s_px = int'(ppos[23:12]); s_py = int'(ppos[11:0]);
          s_cx = int'(cpos[23:12]); s_cy = int'(cpos[11:0]);
          s_fl = psc | csc;
        end
      end
    end
    chk(rst ? $sformatf("rst@%0d", cyc) : $sformatf("px@%0d", cyc),
        {17'd0, hsync, vsync, red, green, blue, frame_start},
        {17'd0, e_hs, e_vs, e_rgb, e_fs});
    drive();
  endtask

  initial begin
    rst = 1'b1;
    ppos = '0; cpos = '0; bpos = '0; psc = 1'b0; csc = 1'b0;
    repeat (10) step();
    rst = 1'b0;
    // three full frames plus a few lines of the fourth
    repeat (3 * FRAME * CLK_DIV + 10 * H_TOT * CLK_DIV) step();
    // mid-frame reset, then two more frames from a clean raster
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    repeat (2 * FRAME * CLK_DIV) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
